// File: rtl/input_skew_feeder_pkg.sv
// input_skew_feeder_pkg
//   Shared types for the systolic-array input skew feeder.
//   feeder_state_t : feeder FSM state encoding (IDLE / STREAM / DRAIN).
//   The per-lane activation type is declared in the top module as lane_t.
//   Its width comes from the top's DATA_WIDTH parameter, and a package
//   cannot take that parameter.
package input_skew_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/input_skew_feeder_if.sv
// input_skew_feeder_if
//   Vector-in / skewed-lanes-out bundle for input_skew_feeder.
//   Upstream : in_valid, in_ready, in_data, in_last
//   Control  : run, flush
//   Array    : lane_valid, lane_data, busy, done
//   underrun_cnt exists only when FEEDER_STATS_EN is defined.
//   master = feeder user (drives upstream/control), slave = the feeder.
interface input_skew_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 2
);
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_LANES*DATA_WIDTH-1:0] in_data;
  logic                            in_last;
  logic                            run;
  logic                            flush;
  logic [NUM_LANES-1:0]            lane_valid;
  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data;
  logic                            busy;
  logic                            done;
`ifdef FEEDER_STATS_EN
  logic [15:0]                     underrun_cnt;

  modport master (
    output in_valid, in_data, in_last, run, flush,
    input  in_ready, lane_valid, lane_data, busy, done, underrun_cnt
  );
  modport slave (
    input  in_valid, in_data, in_last, run, flush,
    output in_ready, lane_valid, lane_data, busy, done, underrun_cnt
  );
`else
  modport master (
    output in_valid, in_data, in_last, run, flush,
    input  in_ready, lane_valid, lane_data, busy, done
  );
  modport slave (
    input  in_valid, in_data, in_last, run, flush,
    output in_ready, lane_valid, lane_data, busy, done
  );
`endif
endinterface

// File: rtl/input_skew_feeder_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered pointers and a combinational head.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous empty (pointers to 0)
//   push, pop  : ignored when full / empty respectively
//   wr_data    : write word; rd_data : current head word (valid when !empty)
//   full, empty: status derived from pointers only, so there is no bypass
//   DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Extra MSB on each pointer distinguishes full from empty.
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/input_skew_feeder.sv
// input_skew_feeder
//   Buffers activation vectors and feeds them into a systolic array with a
//   diagonal skew: lane i of a popped vector appears i+1 cycles after pop.
//   clk, rst_n : clock, async active-low reset
//   bus        : input_skew_feeder_if.slave (in_valid/in_ready/in_data/in_last,
//                run, flush, lane_valid, lane_data, busy, done[, underrun_cnt])
//   Optional: FEEDER_STATS_EN adds underrun_cnt (STREAM cycles with run=1 and
//   the FIFO empty, saturating, cleared by reset or flush).
module input_skew_feeder
  import input_skew_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  input_skew_feeder_if.slave   bus
);
  localparam int VEC_W = NUM_LANES * DATA_WIDTH;
  localparam int CNT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef logic signed [DATA_WIDTH-1:0] lane_t;

  feeder_state_t state_q, state_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [VEC_W:0]   fifo_rd;   // {last, vector}
  logic             head_last;

  logic [NUM_LANES-1:0]                 lv;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] ld;

  // A push in a flush cycle is dropped.
  assign push      = bus.in_valid && !fifo_full && !bus.flush;
  assign pop       = (state_q == ST_IDLE || state_q == ST_STREAM) && bus.run &&
                     !fifo_empty && !bus.flush;
  assign head_last = fifo_rd[VEC_W];

  assign bus.in_ready = !fifo_full;
  assign bus.busy     = (state_q != ST_IDLE);
  // drain_q hits 0 in the cycle the last lane's final element is on the output.
  assign bus.done     = (state_q == ST_DRAIN) && (drain_q == '0);

  sync_fifo #(
    .WIDTH(VEC_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (bus.flush),
    .push    (push),
    .pop     (pop),
    .wr_data ({bus.in_last, bus.in_data}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      // IDLE pops in the same cycle it leaves. A single-vector tile goes
      // straight to DRAIN.
      ST_IDLE, ST_STREAM: begin
        if (pop) begin
          if (head_last) begin
            state_d = ST_DRAIN;
            drain_d = CNT_W'(NUM_LANES - 1);
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_IDLE;
        else               drain_d = drain_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) begin
      state_d = ST_IDLE;
      drain_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Lane i gets an (i+1)-deep chain. Stage 0 loads on pop, or loads a bubble
  // (valid 0, data 0) otherwise. The chains keep shifting in every state.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_t         head;
    logic  [i:0]   vld_pipe;
    lane_t [i:0]   dat_pipe;

    assign head = fifo_rd[i*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else if (bus.flush) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe[0] <= pop;
        dat_pipe[0] <= pop ? head : '0;
        for (int k = 1; k <= i; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          dat_pipe[k] <= dat_pipe[k-1];
        end
      end
    end

    assign lv[i] = vld_pipe[i];
    assign ld[i] = dat_pipe[i];
  end

  assign bus.lane_valid = lv;
  assign bus.lane_data  = ld;

`ifdef FEEDER_STATS_EN
  logic [15:0] underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= '0;
    end else if (bus.flush) begin
      underrun_q <= '0;
    end else if (state_q == ST_STREAM && bus.run && fifo_empty && underrun_q != 16'hFFFF) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign bus.underrun_cnt = underrun_q;
`endif
endmodule

// File: tb/tb_input_skew_feeder.sv
// tb_input_skew_feeder
//   Drives input_skew_feeder (NUM_LANES=2, DATA_WIDTH=16, FIFO_DEPTH=4).
//   A queue model predicts each output cycle: popped vectors push per-lane
//   entries tagged with their due cycle, and the negedge checker pops them.
//   Optional: FEEDER_STATS_EN also checks underrun_cnt.
module tb_input_skew_feeder;
  localparam int DW = 16;
  localparam int NL = 2;
  localparam int FD = 4;
  localparam int M_IDLE = 0, M_STREAM = 1, M_DRAIN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  input_skew_feeder_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();

  input_skew_feeder #(.DATA_WIDTH(DW), .NUM_LANES(NL), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [15:0] d;
  } ent_t;

  logic [32:0] mq[$];       // {last, l1, l0}
  ent_t        lq0[$], lq1[$];
  int          mst = M_IDLE;
  int          drain_end = 0;
  int          cyc = 0;
  int          msz;
  bit          acc = 0, mpush, mpop;
  logic [32:0] mv;
  logic [15:0] und = '0;
  bit          chk_en = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); lq0.delete(); lq1.delete();
      mst = M_IDLE; drain_end = 0; cyc = 0; acc = 0; und = '0;
    end else begin
      msz   = mq.size();
      mpush = bus.in_valid && (msz < FD) && !bus.flush;
      mpop  = !bus.flush && (mst != M_DRAIN) && bus.run && (msz > 0);
      if (bus.flush) und = '0;
      else if (mst == M_STREAM && bus.run && msz == 0 && und != 16'hFFFF) und = und + 16'd1;
      if (bus.flush) begin
        mst = M_IDLE;
        mq.delete(); lq0.delete(); lq1.delete();
      end else if (mst == M_DRAIN && cyc == drain_end) begin
        mst = M_IDLE;
      end
      if (mpop) begin
        mv = mq.pop_front();
        lq0.push_back('{due: cyc + 1, d: mv[15:0]});
        lq1.push_back('{due: cyc + 2, d: mv[31:16]});
        if (mv[32]) begin
          mst = M_DRAIN;
          drain_end = cyc + NL;
        end else begin
          mst = M_STREAM;
        end
      end
      if (mpush) mq.push_back({bus.in_last, bus.in_data});
      acc = mpush;
      cyc++;
    end
  end

  // ---------------- per-cycle checker ----------------
  ent_t e0, e1;
  bit   h0, h1;

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_valid", bus.lane_valid, 0);
        chk("rst_data", bus.lane_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
      end else begin
        h0 = (lq0.size() > 0) && (lq0[0].due == cyc);
        h1 = (lq1.size() > 0) && (lq1[0].due == cyc);
        if (h0) e0 = lq0.pop_front(); else e0 = '{due: 0, d: 16'h0};
        if (h1) e1 = lq1.pop_front(); else e1 = '{due: 0, d: 16'h0};
        chk("l0_valid", bus.lane_valid[0], h0);
        chk("l0_data", bus.lane_data[15:0], e0.d);
        chk("l1_valid", bus.lane_valid[1], h1);
        chk("l1_data", bus.lane_data[31:16], e1.d);
        chk("in_ready", bus.in_ready, mq.size() < FD);
        chk("busy", bus.busy, mst != M_IDLE);
        chk("done", bus.done, (mst == M_DRAIN) && (cyc == drain_end));
`ifdef FEEDER_STATS_EN
        chk("underrun", bus.underrun_cnt, und);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_vec(input logic [15:0] l0, input logic [15:0] l1, input logic last);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = {l1, l0};
    bus.in_last  = last;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(posedge clk);
      #1;
      ok = acc;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("push_accept", ok, 1);
  endtask

  task automatic wait_l0(input string tag);
    int t = 0;
    while (!bus.lane_valid[0] && t < 40) begin
      step(1);
      t++;
    end
    chk(tag, bus.lane_valid[0], 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.run      = 1'b0;
    bus.flush    = 1'b0;
    step(3);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step(1);

    // single-vector tile, lane0 then lane1, done with lane1
    bus.run = 1'b1;
    push_vec(16'h0100, 16'h0200, 1'b1);
    step(6);

    // fill the FIFO with run low; fifth vector waits for space
    bus.run = 1'b0;
    for (int k = 0; k < 4; k++) push_vec(16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b0);
    chk("full_ready", bus.in_ready, 0);
    fork
      push_vec(16'h1004, 16'h2004, 1'b1);
      begin step(3); bus.run = 1'b1; end
    join
    step(10);

    // run dropped for two cycles between pops
    bus.run = 1'b0;
    push_vec(16'h3000, 16'h3100, 1'b0);
    push_vec(16'h3001, 16'h3101, 1'b1);
    bus.run = 1'b1;
    step(1);
    bus.run = 1'b0;
    step(2);
    bus.run = 1'b1;
    step(6);

    // flush while lane1 still holds data; the push in the flush cycle is dropped
    push_vec(16'h4000, 16'h4100, 1'b1);
    wait_l0("flush_wait");
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    step(1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", bus.lane_valid, 0);
    chk("flush_busy", bus.busy, 0);
    chk("flush_done", bus.done, 0);
    chk("flush_ready", bus.in_ready, 1);
    step(4);
    bus.run = 1'b0;

    // STREAM with run high and FIFO empty for three cycles
    push_vec(16'h5000, 16'h5100, 1'b0);
    bus.run = 1'b1;
    step(4);
    bus.run = 1'b0;
`ifdef FEEDER_STATS_EN
    chk("underrun_3", bus.underrun_cnt, 3);
`endif
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
    chk("flush2_busy", bus.busy, 0);
`ifdef FEEDER_STATS_EN
    chk("underrun_clr", bus.underrun_cnt, 0);
`endif

    // random data with run toggling
    fork
      begin
        for (int k = 0; k < 6; k++)
          push_vec(16'($urandom), 16'($urandom), k == 5);
      end
      begin
        repeat (12) begin
          step(1);
          bus.run = 1'($urandom_range(0, 1));
        end
        bus.run = 1'b1;
      end
    join
    step(12);

    // asynchronous reset during DRAIN
    push_vec(16'h6000, 16'h6100, 1'b1);
    wait_l0("drain_wait");
    chk("drain_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.lane_valid, 0);
    chk("arst_data", bus.lane_data, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_ready", bus.in_ready, 1);
    step(2);
    rst_n = 1'b1;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
